// File: rtl/id_instr_queue_if.sv
// IF->ID instruction queue handshake bundle.
// master: the fetch/decode side driving the queue inputs.
// slave:  the queue itself.
`timescale 1ns/1ps
interface id_instr_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_W-1:0] pc_if_i;
  logic [31:0]     instr_if_i;
  logic            valid_if_i;
  logic            ready_if_o;
  logic [PC_W-1:0] pc_id_o;
  logic [31:0]     instr_id_o;
  logic            valid_id_o;
  logic            ready_id_i;
  logic            flush_i;
  logic [CW-1:0]   count_o;

  modport master (
    output pc_if_i, instr_if_i, valid_if_i, ready_id_i, flush_i,
    input  ready_if_o, pc_id_o, instr_id_o, valid_id_o, count_o
  );

  modport slave (
    input  pc_if_i, instr_if_i, valid_if_i, ready_id_i, flush_i,
    output ready_if_o, pc_id_o, instr_id_o, valid_id_o, count_o
  );
endinterface

// File: rtl/id_instr_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO of {pc, instr} pairs between
// fetch and decode. Presents NOP_INSTR when empty, flushes in one cycle.
// Optional feature macro: ID_QUEUE_BYPASS_EN (empty-queue combinational
// pass-through from IF to ID). Default build has no bypass.
`timescale 1ns/1ps
module id_instr_queue #(
  parameter int          DEPTH     = 4,
  parameter int          PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic              clk_i,
  input logic              rst_n_i,
  id_instr_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;

  entry_t        head;
  logic          bypass;
  logic          ready_if, valid_id;
  logic          push, pop;

  assign head = mem[rptr];

  // Bypass only when empty and IF is offering something that is not being flushed.
  always_comb begin
    bypass = 1'b0;
`ifdef ID_QUEUE_BYPASS_EN
    bypass = (count == '0) && q.valid_if_i && !q.flush_i;
`endif
  end

  // Head mux and handshake decode; ready_if comes from registered count only.
  always_comb begin
    ready_if = (count != CW'(DEPTH));
    if (bypass) begin
      valid_id     = 1'b1;
      q.pc_id_o    = q.pc_if_i;
      q.instr_id_o = q.instr_if_i;
    end else begin
      valid_id     = (count != '0) && !q.flush_i;
      q.pc_id_o    = head.pc;
      q.instr_id_o = valid_id ? head.instr : NOP_INSTR;
    end
    // A bypassed instruction consumed this cycle never touches storage.
    push = q.valid_if_i && ready_if && !q.flush_i && !(bypass && q.ready_id_i);
    pop  = valid_id && q.ready_id_i && !bypass;
  end

  assign q.ready_if_o = ready_if;
  assign q.valid_id_o = valid_id;
  assign q.count_o    = count;

  // Pointer and occupancy state; flush wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (q.flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the empty-queue pc output is deterministic.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= '{pc: q.pc_if_i, instr: q.instr_if_i};
    end
  end
endmodule

// File: tb/tb_id_instr_queue.sv
// Directed bench for id_instr_queue with a scoreboard queue of pushed entries.
`timescale 1ns/1ps
module tb_id_instr_queue;
  localparam int          DEPTH = 4;
  localparam int          PC_W  = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [63:0] sb [$];

  always #5 clk = ~clk;

  id_instr_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  id_instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP_INSTR(NOP)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .q       (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive after the edge, check at negedge, update model at posedge.
  task automatic step(input logic vif, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input string tag);
    logic        byp, e_valid, e_ready, push, pop;
    logic [63:0] e_head;
    bus.valid_if_i = vif;
    bus.pc_if_i    = pc;
    bus.instr_if_i = ins;
    bus.ready_id_i = rdy;
    bus.flush_i    = fl;
    byp = 1'b0;
`ifdef ID_QUEUE_BYPASS_EN
    byp = (sb.size() == 0) && vif && !fl;
`endif
    e_ready = (sb.size() != DEPTH);
    e_valid = byp || ((sb.size() != 0) && !fl);
    e_head  = byp ? {pc, ins} : ((sb.size() != 0) ? sb[0] : 64'h0);
    @(negedge clk);
    chk({tag, ".valid"}, 64'(bus.valid_id_o), 64'(e_valid));
    chk({tag, ".ready"}, 64'(bus.ready_if_o), 64'(e_ready));
    chk({tag, ".count"}, 64'(bus.count_o), 64'(sb.size()));
    if (e_valid) begin
      chk({tag, ".pc"},    64'(bus.pc_id_o),    64'(e_head[63:32]));
      chk({tag, ".instr"}, 64'(bus.instr_id_o), 64'(e_head[31:0]));
    end else begin
      chk({tag, ".nop"},   64'(bus.instr_id_o), 64'(NOP));
    end
    push = vif && e_ready && !fl && !(byp && rdy);
    pop  = e_valid && rdy && !byp;
    @(posedge clk);
    if (fl) sb.delete();
    else begin
      if (pop)  void'(sb.pop_front());
      if (push) sb.push_back({pc, ins});
    end
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".count"}, 64'(bus.count_o),    64'h0);
    chk({tag, ".valid"}, 64'(bus.valid_id_o), 64'h0);
    chk({tag, ".ready"}, 64'(bus.ready_if_o), 64'h1);
    chk({tag, ".instr"}, 64'(bus.instr_id_o), 64'(NOP));
    chk({tag, ".pc"},    64'(bus.pc_id_o),    64'h0);
  endtask

  initial begin
    bus.valid_if_i = 1'b0;
    bus.pc_if_i    = '0;
    bus.instr_if_i = '0;
    bus.ready_id_i = 1'b0;
    bus.flush_i    = 1'b0;
    #3;
    chk_reset_vals("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // single push, visible next cycle, then consumed
    step(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0, "push1");
    step(1'b0, 32'h0,   32'h0,         1'b0, 1'b0, "see1");
    step(1'b0, 32'h0,   32'h0,         1'b1, 1'b0, "pop1");

    // fill past DEPTH with ready_id low; pointers start at 1 so they wrap
    for (int i = 0; i < 5; i++)
      step(1'b1, 32'h200 + 32'(4*i), 32'h0010_0093 + 32'(i << 7), 1'b0, 1'b0, "fill");
    // pop at full while IF still offers: no push this cycle
    step(1'b1, 32'h210, 32'h0010_0293, 1'b1, 1'b0, "fullpop");
    for (int i = 0; i < 3; i++)
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "drain");
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "empty");

    // steady state push+pop at count=2
    step(1'b1, 32'h300, 32'h0030_0093, 1'b0, 1'b0, "pre");
    step(1'b1, 32'h304, 32'h0031_0093, 1'b0, 1'b0, "pre");
    for (int i = 0; i < 10; i++)
      step(1'b1, 32'h308 + 32'(4*i), 32'h0032_0093 + 32'(i << 15), 1'b1, 1'b0, "stream");
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "sdrain");
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, "sdrain");

    // flush at count=3 with a competing push
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h400 + 32'(4*i), 32'h0040_0093 + 32'(i), 1'b0, 1'b0, "fpre");
    step(1'b1, 32'h4F0, 32'h0BAD_0093, 1'b1, 1'b1, "flush");
    step(1'b0, 32'h0,   32'h0,         1'b0, 1'b0, "postfl");
    step(1'b1, 32'h500, 32'h0050_0013, 1'b0, 1'b0, "newpush");
    step(1'b0, 32'h0,   32'h0,         1'b1, 1'b0, "newhead");

    // asynchronous reset mid-stream at count=2
    step(1'b1, 32'h600, 32'h0060_0093, 1'b0, 1'b0, "rpre");
    step(1'b1, 32'h604, 32'h0061_0093, 1'b0, 1'b0, "rpre");
    bus.valid_if_i = 1'b0;
    chk("rpre.count", 64'(bus.count_o), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    sb.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;

    // empty queue with IF and ID both ready: bypass or one-cycle latency
    step(1'b1, 32'h200, 32'h0070_0093, 1'b1, 1'b0, "byp");
    step(1'b0, 32'h0,   32'h0,         1'b1, 1'b0, "bypnext");
    step(1'b0, 32'h0,   32'h0,         1'b0, 1'b0, "bypend");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
